// File: rtl/float_divider_seq.sv
// Iterative IEEE-754-style divider: restoring radix-2 mantissa division, one quotient bit per cycle,
// with special-operand handling, saturating over/underflow and valid/ready handshakes.
module float_divider_seq #(
  parameter int FLOAT_SIZE    = 32,
  parameter int EXPONENT_SIZE = 8,
  parameter int MANTISSA_SIZE = 23,
  parameter int BIAS          = 127
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FLOAT_SIZE-1:0] a,
  input  logic [FLOAT_SIZE-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FLOAT_SIZE-1:0] out,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  inexact,
  output logic                  div_by_zero,
  output logic                  invalid
);

  localparam int M  = MANTISSA_SIZE;
  localparam int E  = EXPONENT_SIZE;
  localparam int EW = E + 2;
  localparam int CW = $clog2(M + 2);

  localparam logic [FLOAT_SIZE-1:0] QNAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DIVIDE    = 2'd1,
    NORMALIZE = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [M+1:0]            rem_q, rem_d;
  logic [M:0]              div_q, div_d;
  logic [M+1:0]            quo_q, quo_d;
  logic                    sign_q, sign_d;
  logic [E-1:0]            ea_q, ea_d;
  logic [E-1:0]            eb_q, eb_d;
  logic [FLOAT_SIZE-1:0]   out_q, out_d;
  logic                    ovf_q, ovf_d;
  logic                    unf_q, unf_d;
  logic                    inx_q, inx_d;
  logic                    dbz_q, dbz_d;
  logic                    inv_q, inv_d;

  logic         a_sign, b_sign;
  logic [E-1:0] a_exp, b_exp;
  logic [M-1:0] a_man, b_man;
  logic         a_zero, a_inf, a_nan;
  logic         b_zero, b_inf, b_nan;
  logic         res_sign;

  assign a_sign   = a[FLOAT_SIZE-1];
  assign b_sign   = b[FLOAT_SIZE-1];
  assign a_exp    = a[M +: E];
  assign b_exp    = b[M +: E];
  assign a_man    = a[M-1:0];
  assign b_man    = b[M-1:0];
  assign res_sign = a_sign ^ b_sign;

  // Denormals (exp==0) are flushed and classified as zero.
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (a_exp == '1) && (a_man == '0);
  assign b_inf  = (b_exp == '1) && (b_man == '0);
  assign a_nan  = (a_exp == '1) && (a_man != '0);
  assign b_nan  = (b_exp == '1) && (b_man != '0);

  logic                  spec_hit;
  logic [FLOAT_SIZE-1:0] spec_out;
  logic                  spec_inv;
  logic                  spec_dbz;

  always_comb begin
    spec_hit = 1'b1;
    spec_out = '0;
    spec_inv = 1'b0;
    spec_dbz = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_out = QNAN;
      spec_inv = 1'b1;
    end else if (a_inf) begin
      spec_out = {res_sign, {E{1'b1}}, {M{1'b0}}};
    end else if (b_zero) begin
      spec_out = {res_sign, {E{1'b1}}, {M{1'b0}}};
      spec_dbz = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_out = {res_sign, {(FLOAT_SIZE-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic          div_ge;
  logic [M+1:0]  div_diff;

  assign div_ge   = (rem_q >= {1'b0, div_q});
  assign div_diff = rem_q - {1'b0, div_q};

  logic [M-1:0]  norm_man;
  logic          norm_adj;
  logic          norm_drop;
  logic          norm_inexact;
  logic [EW-1:0] exp_calc;
  logic          exp_ovf;
  logic          exp_unf;

  always_comb begin
    norm_man  = quo_q[M-1:0];
    norm_adj  = 1'b1;
    norm_drop = 1'b0;
    if (quo_q[M+1]) begin
      norm_man  = quo_q[M:1];
      norm_adj  = 1'b0;
      norm_drop = quo_q[0];
    end
    norm_inexact = norm_drop || (rem_q != '0);
    // Two guard bits keep the biased difference representable as a two's-complement value.
    exp_calc = {2'b00, ea_q} - {2'b00, eb_q} + EW'(BIAS) - EW'(norm_adj);
    exp_ovf  = !exp_calc[EW-1] && (exp_calc >= EW'((1 << E) - 1));
    exp_unf  = exp_calc[EW-1] || (exp_calc == '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    div_d   = div_q;
    quo_d   = quo_q;
    sign_d  = sign_q;
    ea_d    = ea_q;
    eb_d    = eb_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    inx_d   = inx_q;
    dbz_d   = dbz_q;
    inv_d   = inv_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = res_sign;
          ea_d   = a_exp;
          eb_d   = b_exp;
          rem_d  = {1'b0, 1'b1, a_man};
          div_d  = {1'b1, b_man};
          quo_d  = '0;
          cnt_d  = '0;
          ovf_d  = 1'b0;
          unf_d  = 1'b0;
          inx_d  = 1'b0;
          if (spec_hit) begin
            out_d   = spec_out;
            dbz_d   = spec_dbz;
            inv_d   = spec_inv;
            state_d = DONE;
          end else begin
            out_d   = '0;
            dbz_d   = 1'b0;
            inv_d   = 1'b0;
            state_d = DIVIDE;
          end
        end
      end

      DIVIDE: begin
        rem_d = (div_ge ? div_diff : rem_q) << 1;
        quo_d = {quo_q[M:0], div_ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(M + 1)) begin
          state_d = NORMALIZE;
        end
      end

      NORMALIZE: begin
        state_d = DONE;
        if (exp_ovf) begin
          out_d = {sign_q, {E{1'b1}}, {M{1'b0}}};
          ovf_d = 1'b1;
          inx_d = 1'b1;
        end else if (exp_unf) begin
          out_d = {sign_q, {(FLOAT_SIZE-1){1'b0}}};
          unf_d = 1'b1;
          inx_d = 1'b1;
        end else begin
          out_d = {sign_q, exp_calc[E-1:0], norm_man};
          inx_d = norm_inexact;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      sign_q  <= 1'b0;
      ea_q    <= '0;
      eb_q    <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inx_q   <= 1'b0;
      dbz_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      sign_q  <= sign_d;
      ea_q    <= ea_d;
      eb_q    <= eb_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      inx_q   <= inx_d;
      dbz_q   <= dbz_d;
      inv_q   <= inv_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out         = out_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign inexact     = inx_q;
  assign div_by_zero = dbz_q;
  assign invalid     = inv_q;

endmodule
